// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int MAX_REQ   = 8;
    localparam int MAX_PTR_W = 3;

    // One-hot of the first set bit of req at or after ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [MAX_PTR_W-1:0] ptr,
                                                   input int n);
        logic [MAX_REQ-1:0] pick;
        int                 idx;
        logic               found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-write-side signals of the arbiter, plus FSM debug taps.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    import fifo_arb_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    // Handshake: a beat on slice i transfers in the cycle where req_vld[i] and ack[i]
    // are both high; ack is the ready, and the producer advances only on ack.
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic                      almost_full;
    logic                      wr_rst_busy;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic                      burst_active;
    arb_state_t                state_dbg;
    logic [PTR_W-1:0]          rr_ptr_dbg;

    modport master (
        input  req, req_vld, req_data, almost_full, wr_rst_busy,
        output gnt, ack, fifo_wr_en, fifo_wr_data, burst_active, state_dbg, rr_ptr_dbg
    );

    modport slave (
        output req, req_vld, req_data, almost_full, wr_rst_busy,
        input  gnt, ack, fifo_wr_en, fifo_wr_data, burst_active, state_dbg, rr_ptr_dbg
    );

endinterface

// File: rtl/fifo_wr_arbiter_pick.sv
// Round-robin first-one picker: rotate req by ptr, find lowest set bit, rotate back.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick_onehot,
    output logic [PTR_W-1:0] pick_idx,
    output logic             pick_any
);

    logic [N-1:0] rot;
    int           src;
    int           first;
    int           unrot;
    logic         found;

    always_comb begin
        rot         = '0;
        src         = 0;
        first       = 0;
        unrot       = 0;
        found       = 1'b0;
        pick_onehot = '0;
        // rot[0] lines up with the requester at ptr, so lowest set bit is the winner.
        for (int i = 0; i < N; i++) begin
            src = i + int'(ptr);
            if (src >= N) src = src - N;
            rot[i] = req[src];
        end
        for (int i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                first = i;
                found = 1'b1;
            end
        end
        unrot = first + int'(ptr);
        if (unrot >= N) unrot = unrot - N;
        if (found) pick_onehot[unrot] = 1'b1;
        pick_idx = PTR_W'(unrot);
        pick_any = found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers,
// with registered write outputs and throttling on almost_full / wr_rst_busy.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 16
) (
    input logic              clk,
    input logic              rst_n,
    fifo_wr_arbiter_if.master bus
);

    localparam int                PTR_W     = $clog2(NUM_REQ);
    localparam int                CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               wr_en_q;
    logic [DATA_W-1:0]  wr_data_q;

    logic [NUM_REQ-1:0] ack;
    logic               ack_any;
    logic               stall;
    logic               req_held;
    logic [DATA_W-1:0]  sel_data;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    rr_priority_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req         (bus.req),
        .ptr         (rr_ptr_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_any    (pick_any)
    );

    assign stall    = bus.almost_full | bus.wr_rst_busy;
    assign ack      = gnt_q & bus.req_vld & {NUM_REQ{~stall}};
    assign ack_any  = |ack;
    assign req_held = |(bus.req & gnt_q);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) sel_data = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.wr_rst_busy && pick_any) begin
                    state_d    = ST_BURST;
                    gnt_d      = pick_onehot;
                    gnt_idx_d  = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            ST_BURST: begin
                if (ack_any) beat_cnt_d = beat_cnt_q + CNT_W'(1);
                // FIFO reset aborts without moving rr_ptr so the same producer resumes first.
                if (bus.wr_rst_busy) begin
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                end else if ((ack_any && beat_cnt_q == LAST_BEAT) || !req_held) begin
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (gnt_idx_q == PTR_MAX) ? '0 : gnt_idx_q + PTR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Write data holds its last value when no beat was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= ack_any;
            if (ack_any) wr_data_q <= sel_data;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.ack          = ack;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign bus.burst_active = (state_q == ST_BURST);
    assign bus.state_dbg    = state_q;
    assign bus.rr_ptr_dbg   = rr_ptr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer model, write scoreboard, grant-order log.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    logic clk;
    logic rst_n;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus();

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .BURST_LEN(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests;
    int         n_fail;
    int         wr_cnt;
    int         onehot_err;
    int         af_ack_err;
    int         premain[4];
    logic [7:0] pdata[4];
    logic [3:0] ack_s;
    logic [3:0] prev_gnt;
    logic [7:0] exp_q[$];
    int         gnt_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // A producer drops req while its final beat is offered, so that beat and the exit coincide.
    task automatic drive_update();
        for (int i = 0; i < 4; i++) begin
            bus.req[i]             = (premain[i] > 1) || (premain[i] == 1 && !bus.gnt[i]);
            bus.req_vld[i]         = (premain[i] > 0);
            bus.req_data[i*8 +: 8] = pdata[i];
        end
    endtask

    task automatic exp_seq(input int base, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(8'(base + k));
    endtask

    task automatic tick();
        @(negedge clk);
        ack_s = bus.ack;
        if ($countones(bus.gnt) > 1 || $countones(ack_s) > 1) onehot_err++;
        if ((bus.almost_full || bus.wr_rst_busy) && ack_s != 0) af_ack_err++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ack_s[i]) begin
                pdata[i]   = pdata[i] + 8'd1;
                premain[i] = premain[i] - 1;
            end
        end
        drive_update();
        if (bus.fifo_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("wr_unexpected", 32'(exp_q.size()), 1);
            else check("wr_data", bus.fifo_wr_data, exp_q.pop_front());
        end
        if (bus.gnt != 0 && prev_gnt == 0) gnt_log.push_back(oh_idx(bus.gnt));
        prev_gnt = bus.gnt;
    endtask

    function automatic logic busy();
        logic b;
        b = (bus.gnt != 0);
        for (int i = 0; i < 4; i++) if (premain[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_gnt(input logic [3:0] want, input int budget, input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.gnt !== want && k < budget);
        check(tag, bus.gnt, want);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy() && k < 400) begin
            tick();
            k++;
        end
        repeat (2) tick();
        check(tag, busy(), 0);
        check({tag, "_q"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.almost_full = 1'b0;
        bus.wr_rst_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            premain[i] = 0;
            pdata[i]   = 8'(i * 64);
        end
        exp_q.delete();
        gnt_log.delete();
        wr_cnt     = 0;
        onehot_err = 0;
        af_ack_err = 0;
        prev_gnt   = '0;
        drive_update();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset values
        do_reset();
        check("rst_gnt", bus.gnt, 0);
        check("rst_wr_en", bus.fifo_wr_en, 0);
        check("rst_wr_data", bus.fifo_wr_data, 0);
        check("rst_burst_active", bus.burst_active, 0);
        check("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        check("rst_rr_ptr", bus.rr_ptr_dbg, 0);

        // 1: single requester, 20 beats -> 16-beat burst, one idle cycle, regrant for 4
        do_reset();
        premain[0] = 20;
        exp_seq(0, 20);
        drive_update();
        tick();
        check("t1_gnt_lat", bus.gnt, 4'b0001);
        check("t1_no_early_wr", bus.fifo_wr_en, 0);
        check("t1_burst_active", bus.burst_active, 1);
        repeat (16) tick();
        check("t1_gnt_drop", bus.gnt, 0);
        check("t1_idle_state", bus.burst_active, 0);
        tick();
        check("t1_regrant", bus.gnt, 4'b0001);
        wait_idle("t1_idle");
        check("t1_wr_cnt", wr_cnt, 20);

        // 2: all four continuously requesting
        do_reset();
        for (int i = 0; i < 4; i++) premain[i] = 1000;
        exp_seq(0, 16); exp_seq(64, 16); exp_seq(128, 16); exp_seq(192, 16); exp_seq(16, 16);
        drive_update();
        begin
            int k;
            k = 0;
            while (gnt_log.size() < 5 && k < 200) begin tick(); k++; end
            while (bus.gnt != 0 && k < 240) begin tick(); k++; end
        end
        for (int i = 0; i < 4; i++) premain[i] = 0;
        drive_update();
        wait_idle("t2_idle");
        check("t2_n_grants", gnt_log.size(), 5);
        check("t2_order0", gnt_log[0], 0);
        check("t2_order1", gnt_log[1], 1);
        check("t2_order2", gnt_log[2], 2);
        check("t2_order3", gnt_log[3], 3);
        check("t2_order4", gnt_log[4], 0);
        check("t2_wr_cnt", wr_cnt, 80);
        check("t2_onehot", onehot_err, 0);

        // 3: almost_full for 5 cycles with beat 7 pending
        do_reset();
        premain[1] = 16;
        exp_seq(64, 16);
        drive_update();
        wait_gnt(4'b0010, 4, "t3_gnt");
        repeat (7) tick();
        bus.almost_full = 1'b1;
        repeat (5) tick();
        check("t3_gnt_held", bus.gnt, 4'b0010);
        check("t3_no_wr", bus.fifo_wr_en, 0);
        check("t3_af_ack", af_ack_err, 0);
        bus.almost_full = 1'b0;
        tick();
        check("t3_gnt_resume", bus.gnt, 4'b0010);
        wait_idle("t3_idle");
        check("t3_wr_cnt", wr_cnt, 16);
        check("t3_n_grants", gnt_log.size(), 1);

        // 4: wr_rst_busy at beat 3 of producer 2 with rr_ptr already at 2
        do_reset();
        premain[1] = 2;
        exp_seq(64, 2); exp_seq(128, 16); exp_seq(192, 16); exp_seq(0, 16);
        drive_update();
        wait_gnt(4'b0010, 4, "t4_g1");
        wait_gnt(4'b0000, 8, "t4_g1_end");
        premain[0] = 16;
        premain[2] = 16;
        premain[3] = 16;
        drive_update();
        wait_gnt(4'b0100, 4, "t4_g2");
        repeat (3) tick();
        bus.wr_rst_busy = 1'b1;
        tick();
        check("t4_gnt_clr", bus.gnt, 0);
        check("t4_no_wr", bus.fifo_wr_en, 0);
        check("t4_burst_off", bus.burst_active, 0);
        repeat (2) tick();
        check("t4_hold_idle", bus.gnt, 0);
        bus.wr_rst_busy = 1'b0;
        tick();
        check("t4_regrant2", bus.gnt, 4'b0100);
        wait_idle("t4_idle");
        check("t4_order3", gnt_log[3], 3);
        check("t4_order4", gnt_log[4], 0);
        check("t4_wr_cnt", wr_cnt, 50);
        check("t4_ack_blocked", af_ack_err, 0);

        // 5: producer 1 drops after 5 beats, producer 3 waiting; rr_ptr wraps to 0
        do_reset();
        premain[1] = 5;
        premain[3] = 3;
        exp_seq(64, 5); exp_seq(192, 3);
        drive_update();
        wait_idle("t5_idle_a");
        check("t5_first", gnt_log[0], 1);
        check("t5_second", gnt_log[1], 3);
        check("t5_rr_ptr", bus.rr_ptr_dbg, 0);
        premain[0] = 1;
        premain[1] = 1;
        exp_seq(0, 1); exp_seq(69, 1);
        drive_update();
        wait_idle("t5_idle_b");
        check("t5_after_wrap", gnt_log[2], 0);
        check("t5_next", gnt_log[3], 1);
        check("t5_wr_cnt", wr_cnt, 10);

        // 6: asynchronous reset mid-burst; afterwards rr_ptr is 0 again
        do_reset();
        premain[1] = 1;
        exp_seq(64, 1);
        drive_update();
        wait_gnt(4'b0010, 4, "t6_g1");
        wait_gnt(4'b0000, 8, "t6_g1_end");
        premain[0] = 16;
        exp_seq(0, 4);
        drive_update();
        wait_gnt(4'b0001, 4, "t6_wrap_pick");
        repeat (4) tick();
        check("t6_pre_rst_wr", bus.fifo_wr_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_gnt", bus.gnt, 0);
        check("t6_async_wr_en", bus.fifo_wr_en, 0);
        check("t6_async_burst", bus.burst_active, 0);
        check("t6_async_data", bus.fifo_wr_data, 0);
        check("t6_async_ptr", bus.rr_ptr_dbg, 0);
        premain[3] = 2;
        exp_seq(4, 12); exp_seq(192, 2);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        prev_gnt = '0;
        drive_update();
        tick();
        check("t6_post_rst_pick", bus.gnt, 4'b0001);
        wait_idle("t6_idle");
        check("t6_order3", gnt_log[3], 3);
        check("t6_wr_cnt", wr_cnt, 19);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
